// File: rtl/cook_timer_pkg.sv
// Shared state encoding, BCD limits and the MM:SS countdown step for the cook timer.
package cook_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX       = 4'd9;
    localparam logic [3:0] SEC_TENS_WRAP = 4'd5;

    // One-second decrement of {min_tens, min_units, sec_tens, sec_units}.
    // Seconds above 59 count down digit by digit; only a minute borrow reloads 59.
    function automatic logic [15:0] bcd_mmss_dec(input logic [15:0] mmss);
        logic [3:0] mt, mu, st, su;
        {mt, mu, st, su} = mmss;
        if (su != 4'd0) begin
            su = su - 4'd1;
        end else if (st != 4'd0) begin
            st = st - 4'd1;
            su = BCD_MAX;
        end else begin
            if (mu != 4'd0) begin
                mu = mu - 4'd1;
            end else begin
                mt = mt - 4'd1;
                mu = BCD_MAX;
            end
            st = SEC_TENS_WRAP;
            su = BCD_MAX;
        end
        return {mt, mu, st, su};
    endfunction

endpackage

// File: rtl/cook_timer_tick_prescaler.sv
// Gated one-second prescaler: counts only while enabled, clears whenever disabled,
// so every enable period starts a fresh full interval.
module tick_prescaler #(
    parameter int TICK_DIV = 100
) (
    input  logic clk_in,
    input  logic reset,
    input  logic enable,
    output logic tick
);
    localparam int                CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk_in) begin
        if (reset || !enable) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = enable && (r_count == LAST);

endmodule

// File: rtl/cook_timer_ctrl.sv
// Microwave cook-time controller: keypad MM:SS entry, gated 1 Hz countdown,
// door interlock, magnetron enable and done indication.
module cook_timer_ctrl
    import cook_timer_pkg::*;
#(
    parameter int TICK_DIV = 100
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_closed,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       magnetron_on,
    output logic       done,
    output logic       running_tick
);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_time, w_time_nxt;
    logic        r_running_tick;
    logic        w_tick, w_run_en, w_digit_ok, w_time_zero;

    // Enable drops in the same cycle as door-open/stop, so a coincident tick never fires.
    assign w_run_en    = (r_state == RUN) && door_closed && !stop_clear;
    assign w_digit_ok  = digit_valid && (digit <= BCD_MAX);
    assign w_time_zero = (r_time == 16'h0000);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk_in (clk_in),
        .reset  (reset),
        .enable (w_run_en),
        .tick   (w_tick)
    );

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state        <= IDLE;
            r_time         <= '0;
            r_running_tick <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_time         <= w_time_nxt;
            r_running_tick <= w_tick;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_time_nxt  = r_time;
        case (r_state)
            IDLE: begin
                if (stop_clear) begin
                    w_time_nxt = '0;
                end else if (start && door_closed && !w_time_zero) begin
                    w_state_nxt = RUN;
                end else if (w_digit_ok) begin
                    w_time_nxt = {r_time[11:0], digit};
                end
            end
            RUN: begin
                if (!door_closed || stop_clear) begin
                    w_state_nxt = PAUSE;
                end else if (w_tick) begin
                    w_time_nxt = bcd_mmss_dec(r_time);
                    if (r_time == 16'h0001) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            PAUSE: begin
                if (stop_clear) begin
                    w_time_nxt  = '0;
                    w_state_nxt = IDLE;
                end else if (start && door_closed) begin
                    w_state_nxt = RUN;
                end
            end
            DONE: begin
                if (stop_clear || start || !door_closed) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_time_nxt  = '0;
            end
        endcase
    end

    assign {min_tens, min_units, sec_tens, sec_units} = r_time;
    assign magnetron_on = (r_state == RUN);
    assign done         = (r_state == DONE);
    assign running_tick = r_running_tick;

endmodule
